lv_dgt_pwm_ctrl_mc: RTL and testbench
=====================================

Name: lv_dgt_pwm_ctrl_mc

Overview:
- Multi-channel successor to the single-channel low-voltage digital PWM control path.
- Per channel it synchronises the analog-side PWM wave and fail-safe wave, deglitches both, and selects between them with the FSM fail-safe enable.
- It inserts programmable dead time on every rising edge, gates the result with the FSM PWM enable, and drives the IO-level PWM.
- It also forwards registered PWM and fail-safe enables to the analog domain and flags rejected glitches.

Parameters:
- CH_NUM, 2, number of independent PWM channels (1..8).
- DGL_W, 4, width of the deglitch-length input.
- DT_W, 8, width of the dead-time input.

Ports:
- i_clk  input  1  system clock
- i_rst_n  input  1  asynchronous active-low reset
- i_ang_dgt_pwm_wv  input  CH_NUM  analog-to-digital PWM wave, asynchronous to i_clk
- i_ang_dgt_pwm_fs  input  CH_NUM  analog-to-digital fail-safe wave, asynchronous to i_clk
- i_fsm_dgt_pwm_en  input  1  FSM PWM enable, synchronous to i_clk
- i_fsm_dgt_fsc_en  input  1  FSM fail-safe select, synchronous to i_clk
- i_dgl_cyc  input  DGL_W  deglitch length in cycles; 0 is treated as 1
- i_dt_cyc  input  DT_W  dead time in cycles; 0 disables dead time
- o_dgt_ang_pwm_en  output  1  registered copy of i_fsm_dgt_pwm_en
- o_dgt_ang_fsc_en  output  1  registered copy of i_fsm_dgt_fsc_en
- o_io_pwm_l2h  output  CH_NUM  per-channel IO PWM, registered
- o_glitch_pls  output  CH_NUM  one-cycle pulse when a glitch is rejected

Behaviour:
- Clock and reset: single clock i_clk; reset i_rst_n is asynchronous, active-low.
- Reset values: every output, sync flop, filter state, counter and FSM state is 0 / OFF. Reset asserted mid-operation forces o_io_pwm_l2h to 0 immediately (asynchronously).
- Enable registers: en_q and fsc_q are registered copies of the FSM inputs. o_dgt_ang_pwm_en = en_q and o_dgt_ang_fsc_en = fsc_q, i.e. one cycle of latency.
- Synchroniser: wv and fs each pass through a 2-flop synchroniser per channel, giving sync_wv and sync_fs.
- Deglitch filter: one filter per signal per channel, each with state filt_q and a counter dcnt.
  - Let N = max(i_dgl_cyc, 1).
  - If sync != filt_q and dcnt == N-1: filt_q <= sync and dcnt <= 0.
  - If sync != filt_q and dcnt < N-1: dcnt++.
  - If sync == filt_q and dcnt != 0: dcnt <= 0 and o_glitch_pls[ch] pulses for one cycle.
  - If the wv and fs filters of one channel reject a glitch in the same cycle, a single pulse is emitted.
  - A change in i_dgl_cyc takes effect immediately. If dcnt >= N-1 while a mismatch is present, the filter updates on that cycle.
- Source select: src[ch] = fsc_q ? filt_fs[ch] : filt_wv[ch] (combinational from registered values).
- Per-channel FSM: states OFF, DT, ON; output o_io_pwm_l2h[ch] = (next_state == ON), registered.
  - OFF: if src && en_q, go to ON when i_dt_cyc == 0, otherwise go to DT with dtcnt = 0. Otherwise stay in OFF.
  - DT: if !src || !en_q, go to OFF. Otherwise, if dtcnt >= i_dt_cyc-1, go to ON; else dtcnt++. The >= comparison keeps dead time bounded when i_dt_cyc shrinks mid-count.
  - ON: if !src || !en_q, go to OFF. Falling edges see no dead time.
  - Toggling fsc_q while in ON with the new src = 1 keeps ON; no dead time is re-inserted.
- Latency from a pin edge to o_io_pwm_l2h:
  - Rising edge: 2 + N + 1 + i_dt_cyc cycles.
  - Falling edge: 2 + N + 1 cycles.
  - Enable deassert to output low: 2 cycles (en_q, then FSM).
- Channel independence: channels are fully independent; shared inputs are i_dgl_cyc, i_dt_cyc and the enables.

Test Plan:
- Reset and enables: reset, then i_fsm_dgt_pwm_en=1 and i_fsm_dgt_fsc_en=0. Expect o_dgt_ang_pwm_en=1 one cycle later, o_dgt_ang_fsc_en=0, and all o_io_pwm_l2h=0 until a wave arrives.
- Steady pulse: dgl=3, dt=5, wv[0] held high for 20 cycles. Expect o_io_pwm_l2h[0] to rise 11 cycles after the pin edge and fall 6 cycles after the pin falling edge.
- Glitch rejection: dgl=4, 2-cycle high pulse on wv[1]. Expect no output change and exactly one o_glitch_pls[1] pulse. A 4-cycle pulse must pass.
- Mode switch: wv=0, fs=1, fsc toggled 0→1. Expect dt cycles plus 2 cycles to ON on channel 0. Then set wv=1 and toggle fsc back 1→0 while ON: output stays 1 with no gap.
- Dead-time abort: dt=10, input falls after 4 cycles in DT. Expect output never rises and the FSM returns to OFF. Also cover dt=0 (no DT state visited) and dgl=0 (behaves as dgl=1).
- Mid-run reset: i_rst_n pulled low while ON on all channels. Expect all outputs 0 immediately; after release, output reappears only after the full 2+N+1+dt latency.

Source files
------------

// File: rtl/lv_dgt_pwm_ctrl_mc.sv
// ----------------------------------------------------------------------------
// lv_dgt_pwm_ctrl_mc
//
// Multi-channel low-voltage digital PWM control path.
//
// Each channel takes an analog-side PWM wave and a fail-safe wave. Both are
// asynchronous to the clock. Each wave is passed through a 2-flop
// synchroniser and then a programmable deglitch filter. The FSM fail-safe
// select chooses which of the two filtered waves is used. A per-channel FSM
// then inserts dead time on rising edges and gates the result with the PWM
// enable to produce the registered IO-level PWM.
//
// Ports:
//   i_clk             system clock
//   i_rst_n           asynchronous active-low reset
//   i_ang_dgt_pwm_wv  [CH_NUM] analog PWM wave (async)
//   i_ang_dgt_pwm_fs  [CH_NUM] analog fail-safe wave (async)
//   i_fsm_dgt_pwm_en  FSM PWM enable
//   i_fsm_dgt_fsc_en  FSM fail-safe select
//   i_dgl_cyc         [DGL_W] deglitch length in cycles (0 behaves as 1)
//   i_dt_cyc          [DT_W]  dead time in cycles (0 disables dead time)
//   o_dgt_ang_pwm_en  registered PWM enable towards the analog side
//   o_dgt_ang_fsc_en  registered fail-safe select towards the analog side
//   o_io_pwm_l2h      [CH_NUM] registered IO PWM
//   o_glitch_pls      [CH_NUM] one-cycle pulse per rejected glitch
// ----------------------------------------------------------------------------
module lv_dgt_pwm_ctrl_mc #(
    parameter int CH_NUM = 2,
    parameter int DGL_W  = 4,
    parameter int DT_W   = 8
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic [CH_NUM-1:0] i_ang_dgt_pwm_wv,
    input  logic [CH_NUM-1:0] i_ang_dgt_pwm_fs,
    input  logic              i_fsm_dgt_pwm_en,
    input  logic              i_fsm_dgt_fsc_en,
    input  logic [DGL_W-1:0]  i_dgl_cyc,
    input  logic [DT_W-1:0]   i_dt_cyc,
    output logic              o_dgt_ang_pwm_en,
    output logic              o_dgt_ang_fsc_en,
    output logic [CH_NUM-1:0] o_io_pwm_l2h,
    output logic [CH_NUM-1:0] o_glitch_pls
);

    // Wave filters are stored in one vector:
    // bits [CH_NUM-1:0] hold the PWM waves.
    // bits [2*CH_NUM-1:CH_NUM] hold the fail-safe waves.
    localparam int FLT_NUM = 2 * CH_NUM;

    localparam logic [1:0] ST_OFF = 2'd0;
    localparam logic [1:0] ST_DT  = 2'd1;
    localparam logic [1:0] ST_ON  = 2'd2;

    logic               en_q;
    logic               fsc_q;
    logic [FLT_NUM-1:0] sync1_q;
    logic [FLT_NUM-1:0] sync2_q;
    logic [FLT_NUM-1:0] filt_all;
    logic [FLT_NUM-1:0] rej_all;
    logic [DGL_W-1:0]   dgl_last;
    logic [DT_W-1:0]    dt_last;

    // A filter accepts a new level once its counter reaches N-1.
    // A length of 0 is treated as 1, so that case also gives 0 here.
    assign dgl_last = (i_dgl_cyc == '0) ? '0 : (i_dgl_cyc - DGL_W'(1));
    assign dt_last  = i_dt_cyc - DT_W'(1);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            en_q    <= 1'b0;
            fsc_q   <= 1'b0;
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            en_q    <= i_fsm_dgt_pwm_en;
            fsc_q   <= i_fsm_dgt_fsc_en;
            sync1_q <= {i_ang_dgt_pwm_fs, i_ang_dgt_pwm_wv};
            sync2_q <= sync1_q;
        end
    end

    assign o_dgt_ang_pwm_en = en_q;
    assign o_dgt_ang_fsc_en = fsc_q;

    // ------------------------------------------------------------------
    // Deglitch filters: one for every synchronised wave.
    // ------------------------------------------------------------------
    genvar gi;
    generate
        for (gi = 0; gi < FLT_NUM; gi++) begin : g_flt
            logic             filt_q;
            logic             filt_d;
            logic [DGL_W-1:0] dcnt_q;
            logic [DGL_W-1:0] dcnt_d;
            logic             rej;

            always_comb begin
                filt_d = filt_q;
                dcnt_d = dcnt_q;
                rej    = 1'b0;
                if (sync2_q[gi] != filt_q) begin
                    // The >= check lets a shortened length take effect
                    // at once, even if the count has already passed N-1.
                    if (dcnt_q >= dgl_last) begin
                        filt_d = sync2_q[gi];
                        dcnt_d = '0;
                    end else begin
                        dcnt_d = dcnt_q + DGL_W'(1);
                    end
                end else if (dcnt_q != '0) begin
                    // The input went back before the filter accepted it:
                    // the pulse is rejected as a glitch.
                    dcnt_d = '0;
                    rej    = 1'b1;
                end
            end

            always_ff @(posedge i_clk or negedge i_rst_n) begin
                if (!i_rst_n) begin
                    filt_q <= 1'b0;
                    dcnt_q <= '0;
                end else begin
                    filt_q <= filt_d;
                    dcnt_q <= dcnt_d;
                end
            end

            assign filt_all[gi] = filt_q;
            assign rej_all[gi]  = rej;
        end
    endgenerate

    // ------------------------------------------------------------------
    // Per-channel source select, dead-time FSM and output registers.
    // ------------------------------------------------------------------
    generate
        for (gi = 0; gi < CH_NUM; gi++) begin : g_ch
            logic            src;
            logic            dt_done;
            logic [1:0]      state_q;
            logic [1:0]      state_d;
            logic [DT_W-1:0] dtcnt_q;
            logic [DT_W-1:0] dtcnt_d;
            logic            pwm_q;
            logic            gl_q;

            assign src = fsc_q ? filt_all[CH_NUM + gi] : filt_all[gi];

            // If the dead time is reduced to 0 while counting, the channel
            // goes to ON directly instead of wrapping the comparison.
            assign dt_done = (i_dt_cyc == '0) || (dtcnt_q >= dt_last);

            always_comb begin
                state_d = state_q;
                dtcnt_d = dtcnt_q;
                case (state_q)
                    ST_OFF: begin
                        if (src && en_q) begin
                            if (i_dt_cyc == '0) begin
                                state_d = ST_ON;
                            end else begin
                                state_d = ST_DT;
                                dtcnt_d = '0;
                            end
                        end
                    end
                    ST_DT: begin
                        if (!src || !en_q) begin
                            state_d = ST_OFF;
                        end else if (dt_done) begin
                            state_d = ST_ON;
                        end else begin
                            dtcnt_d = dtcnt_q + DT_W'(1);
                        end
                    end
                    ST_ON: begin
                        // Falling edges leave ON at once, with no dead time.
                        if (!src || !en_q) begin
                            state_d = ST_OFF;
                        end
                    end
                    default: begin
                        state_d = ST_OFF;
                    end
                endcase
            end

            always_ff @(posedge i_clk or negedge i_rst_n) begin
                if (!i_rst_n) begin
                    state_q <= ST_OFF;
                    dtcnt_q <= '0;
                    pwm_q   <= 1'b0;
                    gl_q    <= 1'b0;
                end else begin
                    state_q <= state_d;
                    dtcnt_q <= dtcnt_d;
                    pwm_q   <= (state_d == ST_ON);
                    // If both filters of the channel reject a glitch in
                    // the same cycle, only one pulse is emitted.
                    gl_q    <= rej_all[gi] | rej_all[CH_NUM + gi];
                end
            end

            assign o_io_pwm_l2h[gi] = pwm_q;
            assign o_glitch_pls[gi] = gl_q;
        end
    endgenerate

endmodule

// File: tb/tb_lv_dgt_pwm_ctrl_mc.sv
// ----------------------------------------------------------------------------
// tb_lv_dgt_pwm_ctrl_mc
//
// Self-checking bench for lv_dgt_pwm_ctrl_mc with CH_NUM=2.
//
// Inputs are driven 1 time unit after each rising clock edge.
// Outputs are sampled at the same point, after that edge's updates.
// In the tables and hand sequences, "cycle c" means the sample taken just
// after the c-th rising edge that follows the stimulus change.
// ----------------------------------------------------------------------------
module tb_lv_dgt_pwm_ctrl_mc;

    localparam int CH_NUM = 2;
    localparam int DGL_W  = 4;
    localparam int DT_W   = 8;
    localparam int WIN    = 50;

    logic              clk;
    logic              rst_n;
    logic [CH_NUM-1:0] wv;
    logic [CH_NUM-1:0] fs;
    logic              pwm_en;
    logic              fsc_en;
    logic [DGL_W-1:0]  dgl;
    logic [DT_W-1:0]   dt;
    logic              ang_pwm_en;
    logic              ang_fsc_en;
    logic [CH_NUM-1:0] io_pwm;
    logic [CH_NUM-1:0] glitch;

    int total = 0;
    int bad   = 0;

    lv_dgt_pwm_ctrl_mc #(
        .CH_NUM (CH_NUM),
        .DGL_W  (DGL_W),
        .DT_W   (DT_W)
    ) dut (
        .i_clk            (clk),
        .i_rst_n          (rst_n),
        .i_ang_dgt_pwm_wv (wv),
        .i_ang_dgt_pwm_fs (fs),
        .i_fsm_dgt_pwm_en (pwm_en),
        .i_fsm_dgt_fsc_en (fsc_en),
        .i_dgl_cyc        (dgl),
        .i_dt_cyc         (dt),
        .o_dgt_ang_pwm_en (ang_pwm_en),
        .o_dgt_ang_fsc_en (ang_fsc_en),
        .o_io_pwm_l2h     (io_pwm),
        .o_glitch_pls     (glitch)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One pulse-test record.
    // exp_rise is the first sample cycle in which the output is high
    // (0 means it never rises).
    // exp_hi is the number of sampled cycles with the output high.
    // exp_gl is the number of glitch pulses on the driven channel.
    typedef struct {
        int ch;
        int dgl;
        int dt;
        int len;
        int exp_rise;
        int exp_hi;
        int exp_gl;
    } vec_t;

    vec_t vecs[8];

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run_vec(input int idx, input vec_t v);
        int rise;
        int hi;
        int gl;
        int other;
        int oc;
        rise  = 0;
        hi    = 0;
        gl    = 0;
        other = 0;
        oc    = v.ch ^ 1;
        dgl   = DGL_W'(v.dgl);
        dt    = DT_W'(v.dt);
        wv[v.ch] = 1'b1;
        for (int c = 1; c <= WIN; c++) begin
            tick();
            if (io_pwm[v.ch]) begin
                hi++;
                if (rise == 0) rise = c;
            end
            if (glitch[v.ch]) gl++;
            if (io_pwm[oc] || glitch[oc]) other++;
            if (c == v.len) wv[v.ch] = 1'b0;
        end
        chk($sformatf("v%0d rise", idx), rise, v.exp_rise);
        chk($sformatf("v%0d high", idx), hi, v.exp_hi);
        chk($sformatf("v%0d glitch", idx), gl, v.exp_gl);
        chk($sformatf("v%0d other_ch", idx), other, 0);
        $display("vec %0d ch=%0d dgl=%0d dt=%0d len=%0d -> rise=%0d high=%0d glitch=%0d",
                 idx, v.ch, v.dgl, v.dt, v.len, rise, hi, gl);
    endtask

    initial begin
        int rise;
        int lows;

        // Latency checks:
        // rise = 3 + N + dt after the pin edge.
        // fall = 3 + N after the pin falling edge.
        //            ch dgl dt len rise hi gl
        vecs[0] = '{0, 3, 5, 20, 11, 15, 0};   // steady pulse
        vecs[1] = '{1, 4, 5,  2,  0,  0, 1};   // glitch rejected
        vecs[2] = '{1, 4, 0,  4,  7,  4, 0};   // 4-cycle pulse passes
        vecs[3] = '{0, 1, 10, 5,  0,  0, 0};   // dead-time abort after 4 DT cycles
        vecs[4] = '{0, 2, 0,  6,  5,  6, 0};   // dt = 0
        vecs[5] = '{1, 0, 3,  8,  7,  5, 0};   // dgl = 0 acts as 1
        vecs[6] = '{0, 0, 0,  1,  4,  1, 0};   // dgl = 0 passes a 1-cycle pulse
        vecs[7] = '{0, 2, 0,  1,  0,  0, 1};   // dgl = 2 rejects a 1-cycle pulse

        rst_n  = 1'b0;
        wv     = '0;
        fs     = '0;
        pwm_en = 1'b0;
        fsc_en = 1'b0;
        dgl    = '0;
        dt     = '0;

        // ---------------- reset and enables ----------------
        tick();
        tick();
        chk("rst io_pwm", int'(io_pwm), 0);
        chk("rst glitch", int'(glitch), 0);
        chk("rst pwm_en", int'(ang_pwm_en), 0);
        rst_n = 1'b1;
        tick();
        pwm_en = 1'b1;
        fsc_en = 1'b0;
        #1;
        chk("en before edge", int'(ang_pwm_en), 0);
        tick();
        chk("en after 1 cycle", int'(ang_pwm_en), 1);
        chk("fsc after 1 cycle", int'(ang_fsc_en), 0);
        for (int c = 0; c < 5; c++) tick();
        chk("idle io_pwm", int'(io_pwm), 0);
        $display("seq reset/enables done");

        // ---------------- table-driven pulses ----------------
        for (int i = 0; i < 8; i++) run_vec(i, vecs[i]);

        // ---------------- mode switch ----------------
        dgl   = 4'd1;
        dt    = 8'd4;
        fs[0] = 1'b1;
        for (int c = 0; c < 10; c++) tick();
        chk("mode fs-only off", int'(io_pwm), 0);
        fsc_en = 1'b1;
        rise = 0;
        for (int c = 1; c <= 20; c++) begin
            tick();
            if (c == 1) chk("mode fsc_en reg", int'(ang_fsc_en), 1);
            if (io_pwm[0] && rise == 0) rise = c;
        end
        chk("mode rise dt+2", rise, 6);
        chk("mode ch1 quiet", int'(io_pwm[1]), 0);
        wv[0] = 1'b1;
        for (int c = 0; c < 10; c++) tick();
        fsc_en = 1'b0;
        lows = 0;
        for (int c = 0; c < 10; c++) begin
            tick();
            if (!io_pwm[0]) lows++;
        end
        chk("mode switch back no gap", lows, 0);
        wv = '0;
        fs = '0;
        for (int c = 0; c < 20; c++) tick();
        chk("mode cleanup", int'(io_pwm), 0);
        $display("seq mode switch rise=%0d gap_cycles=%0d", rise, lows);

        // ---------------- enable deassert ----------------
        dgl = 4'd1;
        dt  = 8'd0;
        wv  = 2'b11;
        for (int c = 0; c < 10; c++) tick();
        chk("both on", int'(io_pwm), 3);
        pwm_en = 1'b0;
        tick();
        chk("en off c1", int'(io_pwm), 3);
        tick();
        chk("en off c2", int'(io_pwm), 0);
        pwm_en = 1'b1;
        tick();
        chk("en on c1", int'(io_pwm), 0);
        tick();
        chk("en on c2", int'(io_pwm), 3);
        $display("seq enable deassert/reassert done");

        // ---------------- mid-run reset ----------------
        dgl = 4'd3;
        dt  = 8'd2;
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        chk("async rst io_pwm", int'(io_pwm), 0);
        chk("async rst pwm_en", int'(ang_pwm_en), 0);
        tick();
        rst_n = 1'b1;
        rise = 0;
        for (int c = 1; c <= 20; c++) begin
            tick();
            if (io_pwm != '0 && rise == 0) begin
                rise = c;
                chk("post rst both ch", int'(io_pwm), 3);
            end
        end
        chk("post rst latency", rise, 8);
        $display("seq mid-run reset rise=%0d", rise);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
